// File: rtl/vec_control_seq_if.sv
// Instruction handshake plus decoded ALU/memory control bundle for vec_control_seq.
// The fetch side drives the master modport; the sequencer uses the slave modport.
interface vec_control_seq_if #(
    parameter int OPCODE_W = 4,
    parameter int IDX_W    = 3
);
    logic                instr_valid;
    logic                instr_ready;
    logic [OPCODE_W-1:0] opcode;
    logic                stall;
    logic [1:0]          vec_alu_op;
    logic                r_mem_1;
    logic                r_mem_2;
    logic                w_mem_2;
    logic                w_mem_3;
    logic [IDX_W-1:0]    rd_idx;
    logic [IDX_W-1:0]    wr_idx;
    logic                busy;
    logic                done;
    logic                illegal;

    modport master (
        output instr_valid, opcode, stall,
        input  instr_ready, vec_alu_op, r_mem_1, r_mem_2, w_mem_2, w_mem_3,
               rd_idx, wr_idx, busy, done, illegal
    );

    modport slave (
        input  instr_valid, opcode, stall,
        output instr_ready, vec_alu_op, r_mem_1, r_mem_2, w_mem_2, w_mem_3,
               rd_idx, wr_idx, busy, done, illegal
    );
endinterface

// File: rtl/vec_control_seq.sv
// Decodes one instruction per handshake and sequences memory enables; vector ops
// issue VEC_LEN/LANES read beats, each retired as a write beat ALU_LAT cycles later.
module vec_control_seq #(
    parameter int OPCODE_W = 4,
    parameter int VEC_LEN  = 8,
    parameter int LANES    = 2,
    parameter int ALU_LAT  = 2
) (
    input  logic             clk,
    input  logic             rst,
    vec_control_seq_if.slave bus
);
    localparam int IDX_W = (VEC_LEN > 2) ? $clog2(VEC_LEN) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(VEC_LEN - LANES);
    localparam logic [IDX_W-1:0]   STEP      = IDX_W'(LANES);
    localparam logic [ALU_LAT-1:0] LAST_MASK = ALU_LAT'(1) << (ALU_LAT - 1);

    typedef enum logic [1:0] {IDLE, SCALAR, VEC_RD, VEC_DRAIN} state_t;

    typedef struct packed {
        logic       vec;
        logic [1:0] alu;
        logic       r1;
        logic       r2;
        logic       w2;
        logic       ill;
    } dec_t;

    // Any opcode above NOP (including nonzero upper bits) is undefined.
    function automatic dec_t decode(input logic [OPCODE_W-1:0] op);
        dec_t d;
        d = '0;
        if (op > OPCODE_W'(5)) begin
            d.ill = 1'b1;
        end else begin
            case (op[2:0])
                3'd0:    begin d.r1 = 1'b1; d.w2 = 1'b1; end
                3'd1:    begin d.r2 = 1'b1; d.w2 = 1'b1; end
                3'd2:    d.w2 = 1'b1;
                3'd3:    begin d.vec = 1'b1; d.alu = 2'b01; end
                3'd4:    begin d.vec = 1'b1; d.alu = 2'b10; end
                default: d = '0;
            endcase
        end
        return d;
    endfunction

    state_t               state;
    dec_t                 op_q;
    dec_t                 dec_in;
    logic [IDX_W-1:0]     rd_idx_q;
    logic [ALU_LAT-1:0]   wv_q;
    logic [IDX_W-1:0]     widx_q [ALU_LAT];
    logic                 run;
    logic                 accept;
    logic                 push;
    logic                 last_wr;
    logic                 in_scalar;
    logic                 in_rd;

    assign dec_in  = decode(bus.opcode);
    assign run     = !bus.stall;
    assign accept  = bus.instr_valid && bus.instr_ready;
    assign push    = (state == VEC_RD) && run;
    // Last write is the only one still outstanding in the delay line.
    assign last_wr = wv_q[ALU_LAT-1] && ((wv_q & ~LAST_MASK) == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            op_q     <= '0;
            rd_idx_q <= '0;
            wv_q     <= '0;
            for (int i = 0; i < ALU_LAT; i++) widx_q[i] <= '0;
        end else if (run) begin
            // Write-delay line: a read beat enters here and emerges ALU_LAT cycles later.
            wv_q[0]   <= push;
            widx_q[0] <= push ? rd_idx_q : '0;
            for (int i = 1; i < ALU_LAT; i++) begin
                wv_q[i]   <= wv_q[i-1];
                widx_q[i] <= widx_q[i-1];
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q     <= dec_in;
                        rd_idx_q <= '0;
                        state    <= dec_in.vec ? VEC_RD : SCALAR;
                    end
                end
                SCALAR: state <= IDLE;
                VEC_RD: begin
                    if (rd_idx_q == LAST_IDX) state <= VEC_DRAIN;
                    else                      rd_idx_q <= rd_idx_q + STEP;
                end
                VEC_DRAIN: if (last_wr) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    assign in_scalar = (state == SCALAR) && run;
    assign in_rd     = (state == VEC_RD) && run;

    assign bus.instr_ready = (state == IDLE) && run;
    assign bus.r_mem_1     = (in_scalar && op_q.r1) || in_rd;
    assign bus.r_mem_2     = (in_scalar && op_q.r2) || in_rd;
    assign bus.w_mem_2     = in_scalar && op_q.w2;
    assign bus.w_mem_3     = wv_q[ALU_LAT-1] && run;
    assign bus.rd_idx      = (state == VEC_RD) ? rd_idx_q : '0;
    assign bus.wr_idx      = wv_q[ALU_LAT-1] ? widx_q[ALU_LAT-1] : '0;
    assign bus.vec_alu_op  = (op_q.vec && (state == VEC_RD || state == VEC_DRAIN)) ? op_q.alu : 2'b00;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = in_scalar || ((state == VEC_DRAIN) && last_wr && run);
    assign bus.illegal     = in_scalar && op_q.ill;
endmodule

// File: tb/tb_vec_control_seq.sv
// Directed bench for vec_control_seq with VEC_LEN=8, LANES=2, ALU_LAT=2 (four beats).
module tb_vec_control_seq;
    localparam int OPCODE_W = 4;
    localparam int VEC_LEN  = 8;
    localparam int LANES    = 2;
    localparam int ALU_LAT  = 2;
    localparam int IDX_W    = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    vec_control_seq_if #(.OPCODE_W(OPCODE_W), .IDX_W(IDX_W)) bus();

    vec_control_seq #(
        .OPCODE_W(OPCODE_W), .VEC_LEN(VEC_LEN), .LANES(LANES), .ALU_LAT(ALU_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Packed layout: ready, alu[1:0], r1, r2, w2, w3, busy, done, illegal, rd_idx[2:0], wr_idx[2:0]
    function automatic logic [15:0] ev(input int rdy, input int alu, input int r1, input int r2,
                                       input int w2, input int w3, input int bsy, input int dn,
                                       input int ill, input int rd, input int wr);
        logic [15:0] v;
        v = {rdy[0], alu[1:0], r1[0], r2[0], w2[0], w3[0], bsy[0], dn[0], ill[0], rd[2:0], wr[2:0]};
        return v;
    endfunction

    // Expected outputs of an unstalled vector op in cycle T+e.
    function automatic logic [15:0] vexp(input int alu, input int e);
        int rd_on;
        int wr_on;
        rd_on = (e >= 1 && e <= 4) ? 1 : 0;
        wr_on = (e >= 3 && e <= 6) ? 1 : 0;
        return ev(0, alu, rd_on, rd_on, 0, wr_on, 1, (e == 6) ? 1 : 0, 0,
                  rd_on ? (e - 1) * 2 : 0, wr_on ? (e - 3) * 2 : 0);
    endfunction

    function automatic logic [15:0] observed();
        return {bus.instr_ready, bus.vec_alu_op, bus.r_mem_1, bus.r_mem_2, bus.w_mem_2,
                bus.w_mem_3, bus.busy, bus.done, bus.illegal, bus.rd_idx, bus.wr_idx};
    endfunction

    task automatic chk(input string tag, input logic [15:0] exp);
        logic [15:0] o;
        #1;
        o = observed();
        tests++;
        assert (o === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, o, exp);
        end
    endtask

    // Presents op in cycle T and returns at the falling edge of T+1 with valid dropped.
    task automatic issue(input logic [3:0] op);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.opcode      = op;
        chk("ready_at_T", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        bus.instr_valid = 1'b0;
    endtask

    logic [15:0] idle_v;
    logic [3:0]  sops [4];
    int          sen  [4][3];
    int          e;

    initial begin
        idle_v          = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.instr_valid = 1'b0;
        bus.opcode      = '0;
        bus.stall       = 1'b0;

        // Reset held, then released.
        repeat (2) @(negedge clk);
        chk("reset_held", idle_v);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_released", idle_v);

        // Scalar ops: INCRI, INCRJ, SETN, NOP.
        sops = '{4'd0, 4'd1, 4'd2, 4'd5};
        sen  = '{'{1, 0, 1}, '{0, 1, 1}, '{0, 0, 1}, '{0, 0, 0}};
        for (int i = 0; i < 4; i++) begin
            issue(sops[i]);
            chk($sformatf("scalar_T1_op%0d", sops[i]),
                ev(0, 0, sen[i][0], sen[i][1], sen[i][2], 0, 1, 1, 0, 0, 0));
            @(negedge clk);
            chk($sformatf("scalar_T2_op%0d", sops[i]), idle_v);
        end

        // SUMFV, no stall.
        issue(4'd3);
        for (int j = 1; j <= 6; j++) begin
            if (j > 1) @(negedge clk);
            chk($sformatf("sumfv_T%0d", j), vexp(1, j));
        end
        @(negedge clk);
        chk("sumfv_T7_idle", idle_v);

        // MULFV with a three-cycle stall covering T+2..T+4.
        issue(4'd4);
        for (int j = 1; j <= 9; j++) begin
            if (j > 1) @(negedge clk);
            bus.stall = (j >= 2 && j <= 4);
            if (j >= 2 && j <= 4) begin
                chk($sformatf("mulfv_stall_T%0d", j), ev(0, 2, 0, 0, 0, 0, 1, 0, 0, 2, 0));
            end else begin
                e = (j < 2) ? j : j - 3;
                chk($sformatf("mulfv_T%0d", j), vexp(2, e));
            end
        end
        @(negedge clk);
        chk("mulfv_T10_idle", idle_v);

        // Undefined opcode behaves as NOP with illegal.
        issue(4'b1010);
        chk("illegal_T1", ev(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
        @(negedge clk);
        chk("illegal_T2", idle_v);

        // Reset asserted during VEC_RD aborts the op without done.
        issue(4'd3);
        chk("abort_T1", vexp(1, 1));
        @(negedge clk);
        rst = 1'b0;
        chk("abort_reset_now", idle_v);
        @(negedge clk);
        rst = 1'b1;
        chk("abort_reset_held", idle_v);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk($sformatf("abort_quiet_%0d", j), idle_v);
        end

        // Valid held high: SUMFV then NOP, second accept one cycle after first done.
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.opcode      = 4'd3;
        chk("b2b_ready_T", idle_v);
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            if (j == 1) bus.opcode = 4'd5;
            chk($sformatf("b2b_sumfv_T%0d", j), vexp(1, j));
        end
        @(negedge clk);
        chk("b2b_T7_ready", idle_v);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        chk("b2b_T8_nop_done", ev(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        @(negedge clk);
        chk("b2b_T9_idle", idle_v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
